// File: rtl/alu_mul_seq_if.sv
// Handshake and shared-ALU bundle for the sequential multiplier.
// slave = sequencer side, master = core/controller side.
interface alu_mul_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        abort;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_carry;

  modport slave (
    input  req_valid, req_a, req_b, abort,
    input  resp_ready, alu_result, alu_carry,
    output req_ready, resp_valid, prod_hi, prod_lo,
    output alu_own, alu_a, alu_b, alu_control
  );

  modport master (
    output req_valid, req_a, req_b, abort,
    output resp_ready, alu_result, alu_carry,
    input  req_ready, resp_valid, prod_hi, prod_lo,
    input  alu_own, alu_a, alu_b, alu_control
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned 32x32->64 shift-and-add multiplier that borrows the
// shared ALU adder for 32 cycles per product.
module alu_mul_seq (
  input logic           clk,
  input logic           rst_n,
  alu_mul_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mcand;
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [4:0]  r_cnt;
  logic        w_accept;
  logic        w_step;

  assign w_accept = (r_state == S_IDLE) & bus.req_valid & ~bus.abort;
  assign w_step   = (r_state == S_RUN) & ~bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN: begin
        if (bus.abort)          w_next = S_IDLE;
        else if (r_cnt == 5'd31) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.abort || bus.resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Carry from the adder becomes bit 63 of the shifted accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= bus.req_a;
      r_acc_hi <= '0;
      r_acc_lo <= bus.req_b;
      r_cnt    <= '0;
    end else if (w_step) begin
      {r_acc_hi, r_acc_lo} <=
        {bus.alu_carry, bus.alu_result, r_acc_lo[31:1]};
      r_cnt <= r_cnt + 5'd1;
    end
  end

  always_comb begin
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_control = 4'b0111;
    if (r_state == S_RUN) begin
      bus.alu_control = 4'b0000;
      bus.alu_a       = r_acc_hi;
      bus.alu_b       = r_acc_lo[0] ? r_mcand : 32'd0;
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_DONE);
  assign bus.alu_own    = (r_state == S_RUN);
  assign bus.prod_hi    = r_acc_hi;
  assign bus.prod_lo    = r_acc_lo;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed + random bench for alu_mul_seq with a behavioural ALU
// and a plain-multiplication product model.
module tb_alu_mul_seq;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  alu_mul_seq_if bus ();

  alu_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: add on 0000, pass-through of a otherwise.
  logic [32:0] w_sum;
  assign w_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_result =
    (bus.alu_control == 4'b0000) ? w_sum[31:0] : bus.alu_a;
  assign bus.alu_carry =
    (bus.alu_control == 4'b0000) ? w_sum[32] : 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Called #1 after an edge while idle; returns #1 after acceptance.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    chk("req_ready_before_start", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
  endtask

  task automatic wait_done(input string tag,
                           input logic [63:0] exp);
    int lat;
    int own;
    lat = 0;
    own = 0;
    while (!bus.resp_valid && lat < 100) begin
      if (bus.alu_own) own++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd32);
    chk({tag, "_own_cycles"}, 64'(own), 64'd32);
    chk({tag, "_prod"}, {bus.prod_hi, bus.prod_lo}, exp);
  endtask

  task automatic take_resp(input string tag);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk({tag, "_req_ready_after"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_resp_valid_after"}, 64'(bus.resp_valid), 64'd0);
  endtask

  task automatic run(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b);
    start(a, b);
    wait_done(tag, model(a, b));
    take_resp(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_alu_own"}, 64'(bus.alu_own), 64'd0);
    chk({tag, "_prod"}, {bus.prod_hi, bus.prod_lo}, 64'd0);
    chk({tag, "_alu_ctl"}, 64'(bus.alu_control), 64'd7);
    chk({tag, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] held;
    int          seen;
    n_assert       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.abort      = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("3x5", 32'd3, 32'd5);
    chk("3x5_literal", model(32'd3, 32'd5), 64'h0000_0000_0000_000F);
    run("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("msb_x2", 32'h8000_0000, 32'd2);
    run("zero", 32'd0, 32'h1234_5678);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) rb = 32'hFFFF_FFFF;
      if (i == 1) ra = 32'd1;
      run($sformatf("rand%0d", i), ra, rb);
    end

    // Backpressure with a queued request hammering during DONE.
    ra = $urandom;
    rb = $urandom;
    start(ra, rb);
    wait_done("bp", model(ra, rb));
    held = {bus.prod_hi, bus.prod_lo};
    bus.req_valid = 1'b1;
    bus.req_a     = 32'd11;
    bus.req_b     = 32'd13;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_prod_stable", {bus.prod_hi, bus.prod_lo}, held);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk("b2b_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("b2b_accepted", 64'(bus.alu_own), 64'd1);
    wait_done("b2b", model(32'd11, 32'd13));
    take_resp("b2b");

    // Abort in IDLE wins over a pending request.
    bus.abort     = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.abort     = 1'b0;
    bus.req_valid = 1'b0;
    chk("idle_abort_own", 64'(bus.alu_own), 64'd0);
    chk("idle_abort_ready", 64'(bus.req_ready), 64'd1);

    // Abort at RUN cycle 10.
    start(32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_own_before", 64'(bus.alu_own), 64'd1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_own_after", 64'(bus.alu_own), 64'd0);
    chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.resp_valid) seen++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_resp", 64'(seen), 64'd0);
    run("7x6", 32'd7, 32'd6);

    // Asynchronous reset at RUN cycle 20.
    start(32'hCAFE_F00D, 32'h8765_4321);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("after_reset", 32'h0001_0000, 32'h0001_0000);
    chk("after_reset_literal",
        model(32'h0001_0000, 32'h0001_0000), 64'h0000_0001_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
